// File: rtl/ws2812_frame_tx_if.sv
// Request and colour-ROM read bus of the WS2812 frame transmitter.
// master = transmitter side, slave = requester / ROM side.
interface ws2812_frame_tx_if #(
  parameter int ADDR_LINES = 8
);
  logic                  i_start;
  logic [ADDR_LINES-1:0] i_base_addr;
  logic [ADDR_LINES-1:0] o_rom_addr;
  logic                  o_rom_ren;
  logic [23:0]           i_rom_data;

  modport master (
    input  i_start,
    input  i_base_addr,
    input  i_rom_data,
    output o_rom_addr,
    output o_rom_ren
  );

  modport slave (
    output i_start,
    output i_base_addr,
    output i_rom_data,
    input  o_rom_addr,
    input  o_rom_ren
  );
endinterface

// File: rtl/ws2812_frame_tx.sv
// Reads NUM_LEDS colour words from a 1-cycle-latency ROM and serialises them as a WS2812 stream.
// Build macro WS_GRB_ORDER_EN: ROM words {R,G,B} are sent in {G,R,B} order.
module ws2812_frame_tx #(
  parameter int NUM_LEDS   = 16,
  parameter int ADDR_LINES = 8,
  parameter int T_BIT      = 62,
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int T_RESET    = 2500
) (
  input  logic               i_clk,
  input  logic               i_rst,
  ws2812_frame_tx_if.master  bus,
  output logic               o_dout,
  output logic               o_busy,
  output logic               o_done
);

  localparam int CNT_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int LED_W   = ADDR_LINES + 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H);
  localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SEND, S_LATCH} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            bit_q, bit_d;
  logic [LED_W-1:0]      led_q, led_d;
  logic [ADDR_LINES-1:0] base_q, base_d;
  logic [23:0]           shreg_q, shreg_d;
  logic [23:0]           nxt_q, nxt_d;
  logic                  done_en_q, done_en_d;
  logic                  dout_q, dout_d;
  logic                  ren_q, ren_d;
  logic [ADDR_LINES-1:0] addr_q, addr_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  function automatic logic [23:0] wire_order(input logic [23:0] w);
`ifdef WS_GRB_ORDER_EN
    return {w[15:8], w[23:16], w[7:0]};
`else
    return w;
`endif
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_LATCH;
      cnt_q     <= '0;
      done_en_q <= 1'b0;
      dout_q    <= 1'b0;
      ren_q     <= 1'b0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_en_q <= done_en_d;
      dout_q    <= dout_d;
      ren_q     <= ren_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    bit_q   <= bit_d;
    led_q   <= led_d;
    base_q  <= base_d;
    shreg_q <= shreg_d;
    nxt_q   <= nxt_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    led_d     = led_q;
    base_d    = base_q;
    shreg_d   = shreg_q;
    nxt_d     = nxt_q;
    done_en_d = done_en_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.i_start) begin
          base_d    = bus.i_base_addr;
          led_d     = '0;
          done_en_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shreg_d = wire_order(bus.i_rom_data);
        bit_d   = 5'd23;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        // Prefetched word for the next LED arrives one cycle after its read pulse.
        if (bit_q == 5'd0 && cnt_q == CNT_W'(1)) nxt_d = bus.i_rom_data;
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q != 5'd0) begin
            bit_d   = bit_q - 5'd1;
            shreg_d = {shreg_q[22:0], 1'b0};
          end else if (led_q == LAST_LED) begin
            state_d = S_LATCH;
          end else begin
            led_d   = led_q + LED_W'(1);
            bit_d   = 5'd23;
            shreg_d = wire_order(nxt_q);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == RST_LAST) begin
          cnt_d     = '0;
          state_d   = S_IDLE;
          done_d    = done_en_q;
          done_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    ren_d  = 1'b0;
    addr_d = addr_q;
    if (state_d == S_FETCH) begin
      ren_d  = 1'b1;
      addr_d = base_d + led_d[ADDR_LINES-1:0];
    end else if (state_d == S_SEND && cnt_d == '0 && bit_d == 5'd0 && led_d != LAST_LED) begin
      ren_d  = 1'b1;
      addr_d = base_d + led_d[ADDR_LINES-1:0] + 1'b1;
    end
    dout_d = (state_d == S_SEND) && (cnt_d < (shreg_d[23] ? T1H_C : T0H_C));
    busy_d = (state_d != S_IDLE);
  end

  assign bus.o_rom_ren  = ren_q;
  assign bus.o_rom_addr = addr_q;
  assign o_dout         = dout_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Randomised self-checking bench for ws2812_frame_tx against a bit-width reference model.
module tb_ws2812_frame_tx;
  localparam int N       = 2;
  localparam int T_BIT   = 62;
  localparam int T0H     = 20;
  localparam int T1H     = 40;
  localparam int T_RESET = 2500;
  localparam int STREAM  = 24 * N * T_BIT;
  localparam int DONE_AT = 3 + STREAM + T_RESET;
  localparam int MAXC    = DONE_AT + 40;
  localparam int RST_AT  = 3 + 29 * T_BIT + 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dout, busy, done;
  logic [23:0] rom [256];
  int n_checks = 0;
  int n_errors = 0;

  ws2812_frame_tx_if #(.ADDR_LINES(8)) bus ();

  ws2812_frame_tx #(
    .NUM_LEDS(N), .ADDR_LINES(8), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .o_dout(dout), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.o_rom_ren) bus.i_rom_data <= rom[bus.o_rom_addr];

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] line_word(input logic [23:0] w);
`ifdef WS_GRB_ORDER_EN
    return {w[15:8], w[23:16], w[7:0]};
`else
    return w;
`endif
  endfunction

  // Hold reset, check reset outputs, release and check the latch gap that follows.
  task automatic do_reset(input int hold, input string name);
    int busy_cnt, hi_cnt, done_cnt;
    @(posedge clk); #1; rst = 1'b1; bus.i_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val({name, "_rst_dout"}, dout, 0);
    check_val({name, "_rst_ren"}, bus.o_rom_ren, 0);
    check_val({name, "_rst_addr"}, bus.o_rom_addr, 0);
    check_val({name, "_rst_done"}, done, 0);
    check_val({name, "_rst_busy"}, busy, 1);
    repeat (hold - 1) @(posedge clk);
    #1; rst = 1'b0;
    busy_cnt = 0; hi_cnt = 0; done_cnt = 0;
    for (int c = 0; c < T_RESET + 50; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (dout) hi_cnt++;
      if (done) done_cnt++;
    end
    check_val({name, "_latch_busy_cycles"}, busy_cnt, T_RESET);
    check_val({name, "_latch_dout_high"}, hi_cnt, 0);
    check_val({name, "_latch_done"}, done_cnt, 0);
  endtask

  // Run one frame, record the line, then compare against widths derived from the ROM contents.
  task automatic run_frame(input logic [7:0] base, input int inject_cyc, input string name);
    bit tr [0:MAXC];
    int ren_cyc [$];
    logic [7:0] ren_addr [$];
    int done_cyc, done_cnt, busy_bad, first_hi, bad_bits, tail_hi;
    logic [23:0] w;
    int width, lead, ones, idx;
    done_cyc = -1; done_cnt = 0; busy_bad = 0;
    @(posedge clk); #1; bus.i_start = 1'b1; bus.i_base_addr = base;
    for (int c = 0; c <= MAXC; c++) begin
      @(negedge clk);
      tr[c] = dout;
      if (bus.o_rom_ren) begin ren_cyc.push_back(c); ren_addr.push_back(bus.o_rom_addr); end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if ((c >= 1 && c < DONE_AT) != busy) busy_bad++;
      @(posedge clk); #1;
      bus.i_start = (c + 1 == inject_cyc);
      bus.i_base_addr = 8'($urandom);
    end
    first_hi = -1;
    for (int c = 0; c <= MAXC; c++) if (tr[c] && first_hi < 0) first_hi = c;
    check_val({name, "_first_high"}, first_hi, 3);
    bad_bits = 0;
    for (int led = 0; led < N; led++) begin
      w = line_word(rom[8'(base + led)]);
      for (int k = 0; k < 24; k++) begin
        width = w[23 - k] ? T1H : T0H;
        idx = 3 + (led * 24 + k) * T_BIT;
        lead = 0; ones = 0;
        for (int j = 0; j < T_BIT; j++) begin
          if (tr[idx + j]) ones++;
          if (tr[idx + j] && lead == j) lead++;
        end
        if (lead != width || ones != width) begin
          if (bad_bits == 0) $display("FAIL %s_bit led=%0d bit=%0d high=%0d exp=%0d", name, led, k, lead, width);
          bad_bits++;
        end
      end
    end
    check_val({name, "_bad_bits"}, bad_bits, 0);
    tail_hi = 0;
    for (int c = 3 + STREAM; c <= MAXC; c++) if (tr[c]) tail_hi++;
    check_val({name, "_latch_high"}, tail_hi, 0);
    check_val({name, "_done_cycle"}, done_cyc, DONE_AT);
    check_val({name, "_done_count"}, done_cnt, 1);
    check_val({name, "_busy_bad"}, busy_bad, 0);
    check_val({name, "_ren_count"}, ren_cyc.size(), N);
    if (ren_cyc.size() > 0) check_val({name, "_ren_first_cycle"}, ren_cyc[0], 1);
    for (int i = 0; i < ren_addr.size() && i < N; i++)
      check_val($sformatf("%s_ren_addr%0d", name, i), ren_addr[i], 8'(base + i));
  endtask

  initial begin
    logic [7:0] b;
    bus.i_start = 1'b0;
    bus.i_base_addr = '0;
    for (int i = 0; i < 256; i++) rom[i] = 24'($urandom);

    do_reset(5, "por");

    rom[8'hFF] = 24'hFFFFFF;
    rom[8'h00] = 24'h000000;
    run_frame(8'hFF, -1, "wrap");

    rom[8'h10] = 24'hA50000;
    run_frame(8'h10, -1, "a5");

    rom[8'h40] = 24'h123456;
    run_frame(8'h40, -1, "order");

    run_frame(8'($urandom), -1, "rnd0");
    run_frame(8'($urandom), 3 + 10 * T_BIT + 5, "busy_start");

    b = 8'($urandom);
    @(posedge clk); #1; bus.i_start = 1'b1; bus.i_base_addr = b;
    @(posedge clk); #1; bus.i_start = 1'b0;
    repeat (RST_AT - 1) @(posedge clk);
    @(negedge clk);
    check_val("midrst_pre_high", dout, 1);
    do_reset(3, "midrst");
    run_frame(8'($urandom), -1, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ws2812_frame_tx.md
Name: ws2812_frame_tx

Overview:
- Downstream consumer of the 24-bit colour ROM (256 x 24, registered read, 1-cycle latency).
- On a start pulse, reads NUM_LEDS consecutive colour words from a base address and serialises them onto the WS2812 data line, MSB first.
- Drives bit timing, inter-word prefetch and the latch/reset gap.
- Sits between the VU level logic, which chooses the frame base address, and the LED strip pin.

Parameters:
- NUM_LEDS, 16, LEDs per frame (1..256).
- ADDR_LINES, 8, ROM address width.
- T_BIT, 62, clock cycles per bit period (1.25 us at 50 MHz).
- T0H, 20, high cycles for a 0 bit (0.4 us).
- T1H, 40, high cycles for a 1 bit (0.8 us).
- T_RESET, 2500, low cycles of the latch gap (50 us).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle frame request.
- i_base_addr  in  ADDR_LINES  ROM address of LED 0; captured on accepted start.
- o_rom_addr  out  ADDR_LINES  ROM read address.
- o_rom_ren  out  1  ROM read enable.
- i_rom_data  in  24  ROM read data, valid the cycle after o_rom_ren.
- o_dout  out  1  WS2812 serial data.
- o_busy  out  1  high whenever not in IDLE.
- o_done  out  1  one-cycle pulse at end of latch gap.

Behaviour:
- Interface: one clock, i_clk; reset i_rst is synchronous and active-high.
- All outputs are registered.
- While i_rst is high: o_dout=0, o_rom_ren=0, o_rom_addr=0, o_done=0, o_busy=1, state forced to LATCH with counter 0.
- After reset release: T_RESET cycles of LATCH, so a strip left half-written by a mid-frame reset is always latched. Then IDLE with o_busy=0 and no o_done pulse.
- Reset mid-frame: o_dout is 0 from the first cycle after the edge on which i_rst was sampled; the frame is abandoned.
- States: IDLE, FETCH, LOAD, SEND, LATCH.
- IDLE:
  - o_dout=0.
  - i_start=1 captures i_base_addr, sets led_idx=0 and goes to FETCH.
  - i_start in any other state is ignored.
- FETCH (1 cycle): o_rom_ren=1, o_rom_addr=base+led_idx, modulo 2^ADDR_LINES (wraps 255->0).
- LOAD (1 cycle): capture i_rom_data into the 24-bit shift register, bit_idx=23, cycle counter=0, go to SEND.
- First bit high phase starts exactly 3 cycles after the cycle i_start is sampled.
- SEND, per bit:
  - o_dout=1 for cycle counts 0..TxH-1, then 0 for the rest of T_BIT, where TxH is T1H for a 1 bit and T0H for a 0 bit.
  - Every bit is exactly T_BIT cycles.
- Prefetch:
  - At cycle 0 of bit 0 of any LED that is not the last: FETCH the next address (o_rom_ren=1 for 1 cycle).
  - Capture the result into a next-word register on the following cycle.
  - On the last cycle of bit 0, move the next word into the shift register.
  - No gap between LEDs: the stream is continuous for 24*NUM_LEDS*T_BIT cycles.
- After the last bit of the last LED: LATCH.
- LATCH: o_dout=0 for T_RESET cycles, then o_done=1 for 1 cycle, then IDLE.
- o_rom_ren pulses exactly NUM_LEDS times per frame.
- Counters:
  - cycle counter width is clog2(max(T_BIT, T_RESET)).
  - led_idx width is ADDR_LINES+1, so NUM_LEDS=256 terminates correctly.

Optional Feature:
- Macro: WS_GRB_ORDER_EN.
- Defined: the ROM word is {R[7:0],G[7:0],B[7:0]}; the shift register loads {G,R,B}, so the line carries G7..G0, R7..R0, B7..B0.
- Undefined: i_rom_data[23:0] is transmitted unchanged, bit 23 first.
- Timing and latency are identical in both builds.

Test Plan:
- Reset then idle: hold i_rst 5 cycles, release -> o_busy=1 for 2500 cycles, then 0; o_dout=0 throughout; o_done never pulses.
- Single LED, NUM_LEDS=1, ROM[0x10]=0xA50000, base=0x10, macro undefined:
  - -> one o_rom_ren with o_rom_addr=0x10.
  - -> first high phase 3 cycles after start.
  - -> high widths 40,20,40,20,20,40,20,40, then sixteen 20s.
  - -> period 62 each, then 2500 low, then o_done.
- Two LEDs, NUM_LEDS=2, base=0xFF, ROM[0xFF]=0xFFFFFF, ROM[0x00]=0x000000:
  - -> addresses 0xFF then 0x00 (wrap).
  - -> 24 highs of 40 followed immediately by 24 highs of 20, with no extra cycles between bit 23 and bit 24.
- Start while busy: pulse i_start mid-SEND -> ignored; frame length and o_rom_ren count unchanged.
- Reset mid-frame: assert i_rst during LED 1 bit 5 -> o_dout=0 next cycle; LATCH for 2500 cycles; a new start afterwards transmits correctly from LED 0.
- WS_GRB_ORDER_EN defined, ROM word 0x123456 -> transmitted bits equal 0x341256, MSB first.
